// File: rtl/run_sequencer_if.sv
// Host/sequencer bundle: go command, preload beats, data-memory port, processor control, result stream, status.
// master = run_sequencer (drives memory, processor start and result stream); slave = host environment.
// No logic inside; timing and backpressure are owned by the sequencer.
interface run_sequencer_if;
  logic        go;
  logic [7:0]  rd_base;
  logic [3:0]  rd_len;
  logic        ld_valid;
  logic [7:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        mem_wr_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wr_data;
  logic [7:0]  mem_rd_data;
  logic        dut_start;
  logic        dut_halt;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] cycle_count;

  modport master (
    input  go, rd_base, rd_len, ld_valid, ld_addr, ld_data, ld_last,
           mem_rd_data, dut_halt, out_ready,
    output ld_ready, mem_wr_en, mem_addr, mem_wr_data, dut_start,
           out_valid, out_data, busy, done, timeout, cycle_count
  );

  modport slave (
    output go, rd_base, rd_len, ld_valid, ld_addr, ld_data, ld_last,
           mem_rd_data, dut_halt, out_ready,
    input  ld_ready, mem_wr_en, mem_addr, mem_wr_data, dut_start,
           out_valid, out_data, busy, done, timeout, cycle_count
  );
endinterface

// File: rtl/run_sequencer.sv
// Sequences a processor test: preload data memory, hold start for START_CYC, run until halt/timeout, dump results.
// Latency: preload writes and dump reads are combinational in the cycle they are presented; phase changes take one edge.
// Backpressure: preload is always accepted in LOAD; dump address/data hold while out_ready is low.
module run_sequencer #(
  parameter int unsigned START_CYC = 2,
  parameter logic [15:0] TIMEOUT   = 16'd65535
) (
  input logic           clk,
  input logic           rst,
  run_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, DUMP, DONE} state_t;

  // ARM counter only needs to reach START_CYC-1 (START_CYC of at least 1 assumed)
  localparam int unsigned   ARM_W    = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(START_CYC - 1);

  state_t            state;
  logic [7:0]        base_q;
  logic [3:0]        len_q;
  logic [3:0]        idx;
  logic [ARM_W-1:0]  arm_cnt;
  logic              dut_start_q;
  logic              busy_q;
  logic              done_q;
  logic              timeout_q;
  logic [15:0]       cc_q;
  logic [15:0]       cc_inc;
  logic [7:0]        dump_addr;

  // run counter sticks at all-ones rather than wrapping
  assign cc_inc    = (cc_q == 16'hFFFF) ? cc_q : cc_q + 16'd1;
  // dump address wraps naturally at 8 bits
  assign dump_addr = base_q + {4'd0, idx};

  // phase sequencing with registered status and processor-start outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      base_q      <= 8'h00;
      len_q       <= 4'd0;
      idx         <= 4'd0;
      arm_cnt     <= '0;
      dut_start_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cc_q        <= 16'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.go) begin
            base_q    <= bus.rd_base;
            len_q     <= bus.rd_len;
            cc_q      <= 16'd0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (bus.ld_valid && bus.ld_last) begin
            arm_cnt <= '0;
            state   <= ARM;
          end
        end
        ARM: begin
          if (arm_cnt == ARM_LAST) begin
            dut_start_q <= 1'b0;
            state       <= RUN;
          end else begin
            arm_cnt <= arm_cnt + ARM_W'(1);
          end
        end
        RUN: begin
          // the halt cycle is itself counted; halt outranks a simultaneous timeout
          cc_q <= cc_inc;
          if (bus.dut_halt || (cc_inc >= TIMEOUT)) begin
            timeout_q   <= !bus.dut_halt;
            dut_start_q <= 1'b1;
            idx         <= 4'd0;
            if (len_q == 4'd0) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              state <= DUMP;
            end
          end
        end
        DUMP: begin
          if (bus.out_ready) begin
            if (idx == len_q - 4'd1) begin
              idx    <= 4'd0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ld_ready  = (state == LOAD);
  assign bus.mem_wr_en = (state == LOAD) && bus.ld_valid;

  // memory port follows the host beat in LOAD and the dump pointer in DUMP
  always_comb begin
    bus.mem_addr    = 8'h00;
    bus.mem_wr_data = 8'h00;
    if (state == LOAD) begin
      bus.mem_addr    = bus.ld_addr;
      bus.mem_wr_data = bus.ld_data;
    end else if (state == DUMP) begin
      bus.mem_addr = dump_addr;
    end
  end

  assign bus.out_valid   = (state == DUMP);
  assign bus.out_data    = (state == DUMP) ? bus.mem_rd_data : 8'h00;
  assign bus.dut_start   = dut_start_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cc_q;

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter: START_CYC, default 2, number of cycles dut_start is held high in ARM before a run.
REQ-002 Parameter: TIMEOUT, default 16'd65535, maximum number of RUN cycles before the run is aborted.
REQ-003 CLK  in  1  Single clock; all state is updated on the rising edge.
REQ-004 Reset  in  1  Asynchronous, active-high reset.
REQ-005 go  in  1  Pulse that begins a sequence; sampled only in IDLE or DONE.
REQ-006 rd_base  in  8  First data-memory address to dump; latched when go is accepted.
REQ-007 rd_len  in  4  Number of result bytes to dump (0-15); latched when go is accepted.
REQ-008 ld_valid, ld_addr[7:0], ld_data[7:0], ld_last  in  1/8/8/1  Preload beat from the host.
REQ-009 ld_ready  out  1  Preload beat accepted this cycle.
REQ-010 mem_wr_en, mem_addr[7:0], mem_wr_data[7:0]  out  1/8/8  Data-memory write/read port.
REQ-011 mem_rd_data  in  8  Data-memory asynchronous read of mem_addr, valid in the same cycle.
REQ-012 dut_start  out  1  Processor start/hold line; high = held, low = running.
REQ-013 dut_halt  in  1  Processor done flag.
REQ-014 out_valid, out_data[7:0]  out  1/8  Result byte stream.
REQ-015 out_ready  in  1  Result stream sink is ready.
REQ-016 busy, done, timeout  out  1/1/1  Status flags.
REQ-017 cycle_count  out  16  Number of cycles spent in RUN during the last run.

Function
REQ-018 The FSM shall have states IDLE, LOAD, ARM, RUN, DUMP and DONE.
REQ-019 IDLE or DONE + go: latch rd_base/rd_len, clear cycle_count/timeout/done, go to LOAD.
REQ-020 In LOAD, ld_ready shall be 1; mem_wr_en = ld_valid, with mem_addr = ld_addr and mem_wr_data = ld_data combinationally in the same cycle.
REQ-021 LOAD: an accepted beat with ld_last=1 shall be written, then the FSM moves to ARM; zero-beat preload is impossible (one beat minimum).
REQ-022 dut_start shall be 1 in every state except RUN.
REQ-023 ARM lasts exactly START_CYC cycles (internal counter), then RUN.
REQ-024 RUN: dut_start=0; cycle_count increments by 1 each RUN cycle and saturates at 16'hFFFF.
REQ-025 RUN: dut_halt=1 sampled -> DUMP next cycle; the halt cycle itself is counted.
REQ-026 RUN: cycle_count reaching TIMEOUT with no halt -> timeout=1, DUMP; halt and timeout in the same cycle -> halt wins, timeout=0.
REQ-027 DUMP: mem_addr = rd_base + idx (8-bit wrap, 8'hFF+1 = 8'h00), out_valid=1, out_data = mem_rd_data, mem_wr_en=0.
REQ-028 DUMP: idx advances only on out_valid & out_ready; out_data and mem_addr are held stable while out_ready=0.
REQ-029 After the rd_len-th handshake -> DONE; rd_len=0 -> DUMP skipped, RUN goes directly to DONE.
REQ-030 DONE: done=1 and held until the next go is accepted; cycle_count and timeout are held.
REQ-031 busy=1 in LOAD, ARM, RUN and DUMP; go while busy shall be ignored.
REQ-032 Outside LOAD, ld_ready=0 and ld beats shall be ignored.
REQ-033 mem_wr_en shall be 0 outside LOAD.

Reset
REQ-034 Reset asserted at any time -> IDLE immediately: dut_start=1, mem_wr_en=0, ld_ready=0, out_valid=0, busy=0, done=0, timeout=0, cycle_count=0, idx=0.
REQ-035 Reset mid-RUN or mid-DUMP shall abort the sequence without further memory writes; the next go restarts the sequence from LOAD.

Verification
REQ-036 Preload {8:00, 9:00, 12:FF, 13:FF(last)}, go with rd_base=10, rd_len=2; halt after 5 RUN cycles -> 4 writes, dut_start low exactly 5 cycles, cycle_count=5, out bytes = mem[10], mem[11], done=1.
REQ-037 Preload {0:00, 1:04, 2:07(last)}, rd_base=4, rd_len=3, out_ready toggling 1/0 -> 3 bytes mem[4..6] in order, each held stable while stalled.
REQ-038 TIMEOUT=20, halt never asserted -> timeout=1, cycle_count=20, dump still runs, done=1.
REQ-039 rd_base=8'hFE, rd_len=4 -> mem_addr sequence FE, FF, 00, 01.
REQ-040 Reset pulse 3 cycles into RUN -> dut_start=1 asynchronously, all status flags 0; a subsequent go completes normally.
REQ-041 go pulsed during RUN and rd_len=0 -> go ignored; halt leads to DONE with zero out_valid cycles.
